// File: rtl/mem_dump_reader_if.sv
// Bus bundle for the memory dump reader: request/status, memory read port and byte stream.
// master is the reader's view, slave is the environment (core, memory, sink) view.
interface mem_dump_reader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              start;
    logic              halted;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        input  start, halted, base_addr, word_count, mem_rd_data, out_ready,
        output mem_rd_en, mem_addr, out_data, out_valid, out_last, busy, done, error
    );

    modport slave (
        output start, halted, base_addr, word_count, mem_rd_data, out_ready,
        input  mem_rd_en, mem_addr, out_data, out_valid, out_last, busy, done, error
    );
endinterface

// File: rtl/mem_dump_reader.sv
// Reads a contiguous range of data-memory words after the core halts and streams
// them out MSB-first as bytes on a valid/ready port.
module mem_dump_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    mem_dump_reader_if.master bus
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, FIN} state_t;

    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ZERO = '0;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [ADDR_W:0]   cnt, cnt_nxt;
    logic [DATA_W-1:0] sh, sh_nxt;
    logic [1:0]        idx, idx_nxt;
    logic              err_q, err_nxt;
    logic              hs;

    assign hs = (state == SEND) && bus.out_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
            addr  <= '0;
            cnt   <= '0;
            sh    <= '0;
            idx   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
            cnt   <= cnt_nxt;
            sh    <= sh_nxt;
            idx   <= idx_nxt;
            err_q <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        cnt_nxt   = cnt;
        sh_nxt    = sh;
        idx_nxt   = idx;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                // A start while a dump is running never reaches here, so it is silently ignored.
                if (bus.start) begin
                    if (bus.halted) begin
                        addr_nxt  = bus.base_addr;
                        cnt_nxt   = bus.word_count;
                        state_nxt = (bus.word_count != CNT_ZERO) ? READ : FIN;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            READ: state_nxt = WAIT;
            WAIT: begin
                sh_nxt    = bus.mem_rd_data;
                idx_nxt   = 2'd0;
                state_nxt = SEND;
            end
            SEND: begin
                if (hs) begin
                    sh_nxt  = {sh[DATA_W-9:0], 8'h00};
                    idx_nxt = idx + 2'd1;
                    if (idx == 2'd3) begin
                        cnt_nxt   = cnt - CNT_ONE;
                        addr_nxt  = addr + ADDR_ONE;
                        state_nxt = (cnt == CNT_ONE) ? FIN : READ;
                    end
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The shift register holds the next byte in its top lane, so stalls keep out_data stable.
    assign bus.mem_rd_en = (state == READ);
    assign bus.mem_addr  = addr;
    assign bus.out_valid = (state == SEND);
    assign bus.out_data  = (state == SEND) ? sh[DATA_W-1 -: 8] : 8'h00;
    assign bus.out_last  = (state == SEND) && (idx == 2'd3) && (cnt == CNT_ONE);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == FIN);
    assign bus.error     = err_q;
endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: table of dump requests, randomized requests against a
// queue-based model of the expected byte/address streams, and hand-timed corner sequences.
module tb_mem_dump_reader;
    localparam int AW = 10;
    localparam int MW = 1 << AW;

    logic clock;
    logic reset_n;
    mem_dump_reader_if #(.ADDR_W(AW), .DATA_W(32)) bus ();

    mem_dump_reader #(.ADDR_W(AW), .DATA_W(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] mem [0:MW-1];
    always @(posedge clock) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];

    int checks = 0;
    int failures = 0;
    int ready_mode = 0;

    logic [15:0] byte_q[$], exp_q[$], addr_q[$], eaddr_q[$];
    int done_cnt, err_cnt, valid_cnt;
    logic        prev_hold;
    logic [9:0]  prev_out;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic int qdiff(input logic [15:0] a[$], input logic [15:0] b[$]);
        int n;
        n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
        return (a.size() == b.size()) ? -1 : n;
    endfunction

    task automatic chk_q(input string nm, input logic [15:0] a[$], input logic [15:0] b[$]);
        int d;
        d = qdiff(a, b);
        checks++;
        if (d != -1) begin
            failures++;
            $display("FAIL %s first_diff=%0d got_len=%0d exp_len=%0d got=%0h exp=%0h", nm, d,
                     a.size(), b.size(), (d < a.size()) ? a[d] : 16'hxxxx,
                     (d < b.size()) ? b[d] : 16'hxxxx);
        end
    endtask

    // Reference: words base..base+count-1 (mod 2^AW), each as 4 bytes MSB first, last flag on final byte.
    function automatic void build_exp(input int base, input int count);
        logic [31:0] w;
        exp_q.delete();
        eaddr_q.delete();
        for (int i = 0; i < count; i++) begin
            eaddr_q.push_back(16'((base + i) % MW));
            w = mem[(base + i) % MW];
            for (int b = 0; b < 4; b++)
                exp_q.push_back({7'd0, (i == count - 1) && (b == 3), w[31 - 8*b -: 8]});
        end
    endfunction

    always @(posedge clock) begin
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ~bus.out_ready;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.mem_rd_en) addr_q.push_back(16'(bus.mem_addr));
            if (bus.out_valid && bus.out_ready) byte_q.push_back({7'd0, bus.out_last, bus.out_data});
            if (bus.out_valid) valid_cnt++;
            if (bus.done) done_cnt++;
            if (bus.error) err_cnt++;
            if (prev_hold) chk("hold_stable", {bus.out_valid, bus.out_last, bus.out_data}, prev_out);
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_out  = {bus.out_valid, bus.out_last, bus.out_data};
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic clear_mon();
        byte_q.delete();
        addr_q.delete();
        done_cnt  = 0;
        err_cnt   = 0;
        valid_cnt = 0;
    endtask

    task automatic run_dump(input int base, input int count, input bit h, input int mode,
                            input bit poke);
        bit finished;
        ready_mode = mode;
        clear_mon();
        build_exp(base, count);
        @(posedge clock); #1;
        bus.start      = 1'b1;
        bus.base_addr  = AW'(base);
        bus.word_count = (AW+1)'(count);
        bus.halted     = h;
        @(posedge clock); #1;
        bus.start  = 1'b0;
        bus.halted = 1'b0;
        finished   = 1'b0;
        for (int c = 0; c < count * 16 + 20; c++) begin
            bus.start = 1'b0;
            if (poke && c == 3) begin
                bus.start      = 1'b1;
                bus.base_addr  = AW'(500);
                bus.word_count = (AW+1)'(1);
                bus.halted     = 1'b1;
            end
            @(posedge clock); #1;
            bus.halted = 1'b0;
            if (!bus.busy && c >= 2) begin
                finished = 1'b1;
                break;
            end
        end
        bus.start = 1'b0;
        chk("dump_terminates", finished, 1'b1);
    endtask

    typedef struct {
        int base;
        int count;
        bit halted;
        int mode;
        bit poke;
        int exp_err;
        int exp_done;
        int exp_bytes;
    } vec_t;

    vec_t vecs[$];
    logic [9:0] exp_s;

    initial begin
        reset_n        = 1'b0;
        bus.start      = 1'b1;
        bus.halted     = 1'b1;
        bus.base_addr  = '0;
        bus.word_count = '0;
        bus.out_ready  = 1'b1;
        for (int i = 0; i < MW; i++) mem[i] = $urandom;
        mem[200] = 32'h0000_0007;
        mem[400] = 32'h1122_3344;
        mem[401] = 32'hAABB_CCDD;
        mem[402] = 32'h0102_0304;
        clear_mon();

        // Reset held with start asserted: everything stays quiet.
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("reset_outputs", {bus.mem_rd_en, bus.mem_addr, bus.out_data, bus.out_valid,
                                  bus.out_last, bus.busy, bus.done, bus.error}, '0);
        end
        @(posedge clock); #1;
        bus.start = 1'b0;
        reset_n   = 1'b1;
        repeat (2) @(posedge clock);

        // Single word with exact cycle timing.
        ready_mode = 0;
        @(posedge clock); #1;
        bus.start = 1'b1; bus.halted = 1'b1; bus.base_addr = AW'(200); bus.word_count = (AW+1)'(1);
        @(posedge clock); #1;
        bus.start = 1'b0;
        @(negedge clock);
        chk("t1_read", {bus.mem_rd_en, bus.busy, bus.mem_addr}, {1'b1, 1'b1, AW'(200)});
        @(negedge clock);
        chk("t2_wait", {bus.out_valid, bus.busy, bus.mem_rd_en}, {1'b0, 1'b1, 1'b0});
        for (int k = 3; k <= 6; k++) begin
            @(negedge clock);
            exp_s = {1'b1, (k == 6), (k == 6) ? 8'h07 : 8'h00};
            chk($sformatf("t%0d_byte", k), {bus.out_valid, bus.out_last, bus.out_data}, exp_s);
        end
        @(negedge clock);
        chk("t7_done", {bus.done, bus.out_valid, bus.busy}, {1'b1, 1'b0, 1'b1});
        @(negedge clock);
        chk("t8_idle", {bus.done, bus.busy}, 2'b00);

        // Table of dump requests.
        vecs.push_back('{200,  1,   1'b1, 0, 1'b0, 0, 1, 4});
        vecs.push_back('{400,  3,   1'b1, 1, 1'b0, 0, 1, 12});
        vecs.push_back('{1023, 2,   1'b1, 0, 1'b0, 0, 1, 8});
        vecs.push_back('{50,   3,   1'b0, 0, 1'b0, 1, 0, 0});
        vecs.push_back('{77,   0,   1'b1, 0, 1'b0, 0, 1, 0});
        vecs.push_back('{10,   2,   1'b1, 0, 1'b1, 0, 1, 8});
        vecs.push_back('{5,    MW,  1'b1, 0, 1'b0, 0, 1, 4*MW});
        vecs.push_back('{900,  4,   1'b1, 2, 1'b0, 0, 1, 16});
        for (int i = 0; i < 12; i++) begin
            int b, c;
            bit h;
            b = $urandom_range(0, MW - 1);
            c = $urandom_range(0, 5);
            h = ($urandom_range(0, 3) != 0);
            vecs.push_back('{b, c, h, 2, 1'b0, h ? 0 : 1, h ? 1 : 0, h ? 4*c : 0});
        end
        foreach (vecs[i]) begin
            run_dump(vecs[i].base, vecs[i].count, vecs[i].halted, vecs[i].mode, vecs[i].poke);
            chk($sformatf("v%0d_err", i), err_cnt, vecs[i].exp_err);
            chk($sformatf("v%0d_done", i), done_cnt, vecs[i].exp_done);
            chk($sformatf("v%0d_nbytes", i), byte_q.size(), vecs[i].exp_bytes);
            if (vecs[i].halted) begin
                chk_q($sformatf("v%0d_bytes", i), byte_q, exp_q);
                chk_q($sformatf("v%0d_addrs", i), addr_q, eaddr_q);
                if (vecs[i].count == 0) chk($sformatf("v%0d_novalid", i), valid_cnt, 0);
            end else begin
                chk($sformatf("v%0d_noreads", i), addr_q.size(), 0);
                chk($sformatf("v%0d_novalid", i), valid_cnt, 0);
            end
        end

        // Reset while byte 2 of the first word is on the bus.
        ready_mode = 0;
        @(posedge clock); #1;
        bus.start = 1'b1; bus.halted = 1'b1; bus.base_addr = AW'(300); bus.word_count = (AW+1)'(2);
        @(posedge clock); #1;
        bus.start = 1'b0;
        clear_mon();
        repeat (4) @(posedge clock);
        #1;
        exp_s = {1'b1, 1'b0, mem[300][15:8]};
        chk("mid_byte2", {bus.out_valid, bus.out_last, bus.out_data}, exp_s);
        reset_n = 1'b0;
        @(posedge clock); #1;
        chk("mid_reset", {bus.out_valid, bus.busy, bus.done}, 3'b000);
        reset_n = 1'b1;
        repeat (4) @(posedge clock);
        chk("mid_no_done", done_cnt, 0);
        run_dump(600, 2, 1'b1, 2, 1'b0);
        chk_q("post_reset_bytes", byte_q, exp_q);
        chk("post_reset_done", done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_dump_reader.md
# mem_dump_reader

Read-back engine for the MIPS-32 core's data memory. After the core halts, it reads a contiguous range of memory words through a synchronous read port and streams them out as bytes on a valid/ready interface. This lets benches and host logic fetch results such as mem[198] through hardware instead of hierarchical peeks. It is the reader counterpart to the program/data writer path that fills memory before execution.

## Interface
- ADDR_W, default 10: memory word-address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, default 32: memory word width; only 32 is supported (4 bytes per word).
- clock  input  1  single clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to begin a dump.
- halted  input  1  core halted flag; a dump is only legal while this is 1.
- base_addr  input  ADDR_W  first word address; sampled on accepted start.
- word_count  input  ADDR_W+1  number of words to dump; sampled on accepted start.
- mem_rd_en  output  1  read strobe to data memory.
- mem_addr  output  ADDR_W  read address; valid while mem_rd_en=1.
- mem_rd_data  input  DATA_W  read data; valid exactly one cycle after mem_rd_en.
- out_data  output  8  byte stream, most-significant byte of each word first.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the byte this cycle.
- out_last  output  1  high with the final byte of the final word.
- busy  output  1  high from accepted start until return to IDLE.
- done  output  1  one-cycle pulse when the dump completes.
- error  output  1  one-cycle pulse when start arrives while halted=0.

## Operation
- States:
  - IDLE: wait for start.
  - READ: assert mem_rd_en and mem_addr.
  - WAIT: capture mem_rd_data into a 32-bit shift register.
  - SEND: present 4 bytes.
  - FIN: pulse done.
- IDLE + start + halted=1:
  - Latch base_addr and word_count; set busy.
  - Go to READ if word_count≠0, otherwise go to FIN.
- IDLE + start + halted=0: pulse error next cycle; stay in IDLE; latch nothing.
- start while busy is ignored, with no error.
- READ lasts one cycle, then goes to WAIT. WAIT lasts one cycle, then goes to SEND with byte index 0.
- SEND:
  - out_valid=1 and out_data = word[31:24], [23:16], [15:8], [7:0] in turn.
  - The index advances only on a cycle with out_valid&&out_ready.
  - out_data, out_valid and out_last hold stable while out_ready=0.
- After the 4th byte is accepted:
  - Decrement the remaining count and increment the address, wrapping 2^ADDR_W−1 to 0.
  - If the count is now 0, go to FIN; otherwise go to READ.
- out_last=1 only during SEND with byte index 3 and remaining count 1.
- FIN: done=1 for exactly one cycle; busy drops to 0 on entering IDLE.
- halted falling during a dump does not abort it; the dump runs to completion.
- Byte width rule: the count register is ADDR_W+1 bits. word_count=2^ADDR_W dumps the whole memory once.

## Timing
- Reset: while reset_n=0 at a clock edge, the state goes to IDLE and the following outputs are 0: mem_rd_en, mem_addr, out_data, out_valid, out_last, busy, done, error.
- Reset mid-operation aborts the dump immediately with no done pulse; stream bytes are dropped.
- For a start accepted at edge T:
  - busy=1 and mem_rd_en=1 from T+1.
  - The data capture edge is T+2.
  - out_valid=1 from T+3.
- Steady state with out_ready held 1: 6 cycles per word (READ, WAIT, 4×SEND).
- With word_count=0, done pulses in cycle T+1..T+2 and out_valid is never asserted.
- done asserts the cycle after the final byte handshake; busy is 0 the cycle after that.
- error asserts the cycle after the offending start, for one cycle.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with start=1 → every output stays 0 and no mem_rd_en is issued.
- Single word: mem[200]=7, halted=1, base 200, count 1, out_ready=1:
  - Required: mem_addr=200 at T+1; bytes 00,00,00,07 on T+3..T+6.
  - Required: out_last only on 07; done at T+7.
- Back-pressure: 3 words 0x11223344, 0xAABBCCDD, 0x01020304, with out_ready toggling 1,0,1,0:
  - Required: 12 bytes in MSB-first order.
  - Required: out_data stable across every ready=0 cycle; single out_last on 04.
- Wrap: ADDR_W=10, base 1023, count 2 → mem_addr sequence 1023 then 0; 8 bytes; one done pulse.
- Illegal and empty requests:
  - start with halted=0 → error pulse, busy stays 0, no reads.
  - count 0 with halted=1 → done pulse, no out_valid.
  - start while busy → ignored.
- Mid-dump reset: drop reset_n during SEND byte 2:
  - Required: next edge shows out_valid=0, busy=0, no done.
  - Required: a subsequent start dumps correctly from the new base.
